// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS coprocessor-0 register file with Count/Compare timer,
// interrupt sources and prioritised exception recording.
// Ports:
//   clock, resetn      - rising-edge clock, asynchronous active-low reset
//   valid, ex, eret    - commit strobes (ex/eret only act when valid)
//   epc_in, is_bd      - faulting PC and delay-slot flag for EPC/BD
//   badvaddr_in        - faulting address for address-error causes
//   hw_int             - level-sensitive external interrupt lines
//   cp0_reg, cp0_sel   - MFC0/MTC0 register address
//   we, value          - MTC0 write strobe and data
//   value_out          - MFC0 read data (combinational)
//   epc_out            - current EPC for the ERET redirect
//   int_req            - enabled pending interrupt, from registered state only
module cp0_regfile #(
  parameter int HW_INT_W  = 6,
  parameter int COUNT_DIV = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                valid,
  input  logic [7:0]          ex,
  input  logic [31:0]         epc_in,
  input  logic                is_bd,
  input  logic [31:0]         badvaddr_in,
  input  logic                eret,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic [4:0]          cp0_reg,
  input  logic [2:0]          cp0_sel,
  input  logic                we,
  input  logic [31:0]         value,
  output logic [31:0]         value_out,
  output logic [31:0]         epc_out,
  output logic                int_req
);
  logic [31:0] badvaddr, count, compare, epc, div;
  logic [7:0]  im, ip;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code, code;
  logic        exl, ie, bd, ti;
  logic        ex_go, eret_go, is_bad, tick, ti_set;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign ex_go      = valid & |ex;
  assign eret_go    = valid & eret & ~ex_go;
  assign wr_count   = we & (cp0_sel == 3'd0) & (cp0_reg == 5'd9);
  assign wr_compare = we & (cp0_sel == 3'd0) & (cp0_reg == 5'd11);
  assign wr_status  = we & (cp0_sel == 3'd0) & (cp0_reg == 5'd12);
  assign wr_cause   = we & (cp0_sel == 3'd0) & (cp0_reg == 5'd13);
  assign wr_epc     = we & (cp0_sel == 3'd0) & (cp0_reg == 5'd14);
  // Lowest set index wins.
  assign code = ex[0] ? 5'h00 : ex[1] ? 5'h04 : ex[2] ? 5'h0a : ex[3] ? 5'h0c :
                ex[4] ? 5'h08 : ex[5] ? 5'h09 : ex[6] ? 5'h04 : 5'h05;
  // Winner is an address error (ex[1], ex[6] or ex[7]).
  assign is_bad = ~ex[0] & (ex[1] | (~|ex[5:2] & (ex[6] | ex[7])));
  assign tick   = (div == 32'(COUNT_DIV - 1)) & ~wr_count;
  assign ti_set = tick & (count + 32'd1 == compare);
  // Timer interrupt shares IP[7] with the top hardware line.
  assign ip      = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign int_req = ie & ~exl & |(ip & im);
  assign epc_out = epc;
  always_comb begin
    value_out = 32'd0;
    if (cp0_sel == 3'd0)
      case (cp0_reg)
        5'd8:    value_out = badvaddr;
        5'd9:    value_out = count;
        5'd11:   value_out = compare;
        5'd12:   value_out = {16'd0, im, 6'd0, exl, ie};
        5'd13:   value_out = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};
        5'd14:   value_out = epc;
        default: value_out = 32'd0;
      endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      div      <= '0;
      im       <= '0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exc_code <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ti       <= 1'b0;
    end else begin
      div      <= (wr_count | tick) ? 32'd0 : div + 32'd1;
      count    <= wr_count ? value : tick ? count + 32'd1 : count;
      compare  <= wr_compare ? value : compare;
      ti       <= wr_compare ? 1'b0 : ti_set ? 1'b1 : ti;
      ip_hw    <= 6'(hw_int);
      ip_sw    <= wr_cause ? value[9:8] : ip_sw;
      im       <= wr_status ? value[15:8] : im;
      ie       <= wr_status ? value[0] : ie;
      exl      <= ex_go ? 1'b1 : eret_go ? 1'b0 : wr_status ? value[1] : exl;
      exc_code <= ex_go ? code : exc_code;
      badvaddr <= (ex_go & is_bad) ? badvaddr_in : badvaddr;
      // A nested exception keeps the original EPC/BD and also blocks MTC0 to EPC.
      epc      <= (ex_go & ~exl) ? epc_in : (wr_epc & ~ex_go) ? value : epc;
      bd       <= (ex_go & ~exl) ? is_bd : bd;
    end
  end
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed stimulus against a behavioural model of cp0_regfile.
module tb_cp0_regfile;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  ex = '0;
  logic [31:0] epc_in = '0;
  logic        is_bd = 1'b0;
  logic [31:0] badvaddr_in = '0;
  logic        eret = 1'b0;
  logic [5:0]  hw_int = '0;
  logic [4:0]  cp0_reg = '0;
  logic [2:0]  cp0_sel = '0;
  logic        we = 1'b0;
  logic [31:0] value = '0;
  logic [31:0] value_out, epc_out;
  logic        int_req;
  int n_tests = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  cp0_regfile #(.HW_INT_W(6), .COUNT_DIV(2)) dut (
    .clock(clock), .resetn(resetn), .valid(valid), .ex(ex), .epc_in(epc_in),
    .is_bd(is_bd), .badvaddr_in(badvaddr_in), .eret(eret), .hw_int(hw_int),
    .cp0_reg(cp0_reg), .cp0_sel(cp0_sel), .we(we), .value(value),
    .value_out(value_out), .epc_out(epc_out), .int_req(int_req)
  );

  always #10 clock = ~clock;

  // Model state, named after the architectural fields.
  logic [31:0] m_bva, m_cnt, m_cmp, m_epc;
  logic [7:0]  m_im;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic        m_exl, m_ie, m_bd, m_ti;
  int          m_ph;
  int          codes[8] = '{0, 4, 10, 12, 8, 9, 4, 5};

  task automatic m_reset();
    m_bva = 0; m_cnt = 0; m_cmp = 0; m_epc = 0; m_im = 0; m_iphw = 0; m_ipsw = 0;
    m_code = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ph = 0;
  endtask

  function automatic logic [7:0] m_ip();
    return {m_iphw[5] | m_ti, m_iphw[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
    if (s != 0) return 32'd0;
    case (r)
      5'd8:  return m_bva;
      5'd9:  return m_cnt;
      5'd11: return m_cmp;
      5'd12: return {16'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13: return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_ie && !m_exl && ((m_ip() & m_im) != 0);
  endfunction

  function automatic bit wr(input int r);
    return we && cp0_sel == 0 && cp0_reg == 5'(r);
  endfunction

  // One clock: next state from the current inputs, committed at the edge.
  task automatic tick();
    logic [31:0] n_bva = m_bva, n_cnt = m_cnt, n_cmp = m_cmp, n_epc = m_epc;
    logic [7:0]  n_im = m_im;
    logic [1:0]  n_ipsw = m_ipsw;
    logic [4:0]  n_code = m_code;
    logic        n_exl = m_exl, n_ie = m_ie, n_bd = m_bd, n_ti = m_ti;
    int          n_ph = m_ph, w = 0;
    bit          fire = valid && ex != 0;
    bit          er = valid && eret && !fire;
    for (int i = 7; i >= 0; i--) if (ex[i]) w = i;
    if (wr(9)) begin
      n_cnt = value; n_ph = 0;
    end else if (m_ph + 1 == 2) begin
      n_ph = 0; n_cnt = m_cnt + 1;
      if (n_cnt == m_cmp) n_ti = 1;
    end else n_ph = m_ph + 1;
    if (wr(11)) begin n_cmp = value; n_ti = 0; end
    if (wr(12)) begin n_im = value[15:8]; n_ie = value[0]; n_exl = value[1]; end
    if (er) n_exl = 0;
    if (wr(13)) n_ipsw = value[9:8];
    if (wr(14) && !fire) n_epc = value;
    if (fire) begin
      n_exl = 1;
      n_code = 5'(codes[w]);
      if (w == 1 || w == 6 || w == 7) n_bva = badvaddr_in;
      if (!m_exl) begin n_epc = epc_in; n_bd = is_bd; end
    end
    @(posedge clock);
    m_bva = n_bva; m_cnt = n_cnt; m_cmp = n_cmp; m_epc = n_epc; m_im = n_im;
    m_iphw = hw_int; m_ipsw = n_ipsw; m_code = n_code; m_exl = n_exl; m_ie = n_ie;
    m_bd = n_bd; m_ti = n_ti; m_ph = n_ph;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [4:0] r, input logic [31:0] exp);
    cp0_reg = r; cp0_sel = 0; #1;
    chk(name, value_out, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] v);
    cp0_reg = r; cp0_sel = 0; we = 1; value = v;
    tick();
    we = 0;
  endtask

  task automatic commit_ex(input logic [7:0] e, input logic [31:0] pc, input logic b, input logic [31:0] bad);
    valid = 1; ex = e; epc_in = pc; is_bd = b; badvaddr_in = bad;
    tick();
    valid = 0; ex = 0;
  endtask

  task automatic do_reset();
    resetn = 0; m_reset();
    valid = 0; ex = 0; eret = 0; we = 0; hw_int = 0;
    repeat (2) @(posedge clock);
    #1 resetn = 1;
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clock) begin
    if (run_cmp) begin
      n_tests++;
      if (value_out !== m_read(cp0_reg, cp0_sel) || epc_out !== m_epc || int_req !== m_int()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: value_out=%08h/%08h epc_out=%08h/%08h int_req=%0b/%0b",
                 $time, value_out, m_read(cp0_reg, cp0_sel), epc_out, m_epc, int_req, m_int());
      end
    end
  end

  initial begin
    bit hit;
    m_reset();
    #5;
    run_cmp = 1;
    // 1: reset and count rate
    do_reset();
    rd("rst_status", 12, 0);
    rd("rst_cause", 13, 0);
    rd("rst_epc", 14, 0);
    chk("rst_int_req", {31'd0, int_req}, 0);
    rd("cnt0", 9, 0); tick();
    rd("cnt1", 9, 0); tick();
    rd("cnt2", 9, 1); tick();
    rd("cnt3", 9, 1); tick();
    rd("cnt4", 9, 2);
    mtc0(11, 5);
    mtc0(9, 32'hFFFF_FFFF);
    rd("cnt_load", 9, 32'hFFFF_FFFF); tick();
    rd("cnt_hold", 9, 32'hFFFF_FFFF); tick();
    rd("cnt_wrap", 9, 0);
    rd("wrap_no_ti", 13, 0);
    rd("sel_other", 9, 0);
    cp0_sel = 1; #1; chk("sel1_reads0", value_out, 0); cp0_sel = 0;
    // 2: timer interrupt
    do_reset();
    mtc0(11, 3);
    mtc0(12, 32'h0000_8001);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cp0_reg = 9; #1;
      if (value_out == 3) hit = 1; else tick();
    end
    chk("count_reaches_3", {31'd0, hit}, 1);
    rd("ti_set", 13, 32'h4000_8000);
    chk("ti_int_req", {31'd0, int_req}, 1);
    mtc0(11, 100);
    rd("ti_clear", 13, 0);
    chk("ti_int_clear", {31'd0, int_req}, 0);
    // 3: nested exception
    do_reset();
    commit_ex(8'h10, 32'hBFC0_0100, 1, 0);
    rd("sys_epc", 14, 32'hBFC0_0100);
    rd("sys_cause", 13, 32'h8000_0020);
    rd("sys_status", 12, 32'h0000_0002);
    commit_ex(8'h08, 32'hBFC0_0200, 0, 0);
    chk("nested_epc", epc_out, 32'hBFC0_0100);
    rd("nested_cause", 13, 32'h8000_0030);
    // 4: priority and BadVAddr
    commit_ex(8'b1100_0100, 32'h0, 0, 32'h1234);
    rd("ri_cause", 13, 32'h8000_0028);
    rd("ri_bva", 8, 0);
    commit_ex(8'b1000_0000, 32'h0, 0, 32'h1234);
    rd("ades_cause", 13, 32'h8000_0014);
    rd("ades_bva", 8, 32'h1234);
    // 5: simultaneous events
    valid = 1; eret = 1; cp0_reg = 12; we = 1; value = 32'h2;
    tick();
    valid = 0; eret = 0; we = 0;
    rd("eret_wins", 12, 0);
    valid = 1; ex = 8'h20; epc_in = 32'h400; is_bd = 0; cp0_reg = 14; we = 1; value = 32'hDEAD;
    tick();
    valid = 0; ex = 0; we = 0;
    chk("ex_beats_mtc0", epc_out, 32'h400);
    rd("bp_cause", 13, 32'h0000_0024);
    // 6: interrupt masking
    do_reset();
    mtc0(12, 32'h0000_0001);
    hw_int = 6'b000100;
    tick();
    rd("ip4_set", 13, 32'h0000_1000);
    chk("ip4_masked", {31'd0, int_req}, 0);
    mtc0(12, 32'h0000_1001);
    chk("ip4_enabled", {31'd0, int_req}, 1);
    mtc0(13, 32'h0000_0100);
    rd("sw_ip", 13, 32'h0000_1100);
    resetn = 0; m_reset(); hw_int = 0; #1;
    chk("async_rst_int", {31'd0, int_req}, 0);
    chk("async_rst_epc", epc_out, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    tick();
    run_cmp = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Parametrised coprocessor-0 register file for the MIPS pipeline. It holds BadVAddr, Count, Compare, Status, Cause and EPC. It adds a programmable Count/Compare timer, hardware and software interrupt sources and prioritised multi-cause exception recording. It sits beside the writeback stage: it commits exceptions and ERET, serves MFC0/MTC0, and returns an interrupt request and the EPC to the fetch redirect logic.

## Interface

**Parameters**
- HW_INT_W, default 6: number of hardware interrupt lines, 1..6; hw_int[i] maps to Cause.IP[i+2].
- COUNT_DIV, default 2: Count increments once every COUNT_DIV clocks; must be ≥ 1.

**Ports**
- clock, in, 1: single clock; all state updates on the rising edge.
- resetn, in, 1: reset is asynchronous and active-low.
- valid, in, 1: the committing instruction is real; gates ex and eret.
- ex, in, 8: one-hot-or-more exception flags; see priority below.
- epc_in, in, 32: PC of the faulting instruction (already branch-adjusted by the pipeline).
- is_bd, in, 1: the faulting instruction is in a delay slot.
- badvaddr_in, in, 32: faulting address for address-error causes.
- eret, in, 1: ERET commit.
- hw_int, in, HW_INT_W: level-sensitive external interrupts, asynchronous to software.
- cp0_reg, in, 5: MFC0/MTC0 register number.
- cp0_sel, in, 3: select field; only 0 is implemented.
- we, in, 1: MTC0 write enable.
- value, in, 32: MTC0 write data.
- value_out, out, 32: MFC0 read data, combinational.
- epc_out, out, 32: current EPC, for the ERET redirect.
- int_req, out, 1: interrupt pending and enabled; registered-state only, with no combinational path from any input.

## Operation

**Registers** (sel 0). Unimplemented fields read 0, and reads of any other reg/sel return 0.
- BadVAddr (8): read-only.
- Count (9): read/write.
- Compare (11): read/write.
- Status (12): IM[15:8] R/W, EXL[1] R/W, IE[0] R/W.
- Cause (13): BD[31] RO, TI[30] RO, IP[15:10] RO, IP[9:8] R/W (software interrupts), ExcCode[6:2] RO.
- EPC (14): read/write.

**Exception priority.** The lowest index wins:
- ex[0] Int → 0x00
- ex[1] AdEL-fetch → 0x04
- ex[2] RI → 0x0a
- ex[3] Ov → 0x0c
- ex[4] Sys → 0x08
- ex[5] Bp → 0x09
- ex[6] AdEL-data → 0x04
- ex[7] AdES → 0x05

**Exception commit** (|ex & valid):
- ExcCode takes the winner's code.
- EXL is set to 1.
- BadVAddr is loaded from badvaddr_in only if the winner is ex[1], ex[6] or ex[7].
- EPC and BD are loaded from epc_in and is_bd only if EXL was 0 before the edge. If EXL was already 1, both are held.

**ERET** (eret & valid, no exception): EXL is cleared.

**Update precedence per register:** exception > ERET > MTC0. When a higher-precedence event occurs, an MTC0 in the same cycle to the affected field is dropped.

**Timer:**
- A divider counts 0..COUNT_DIV-1. Count increments when the divider wraps to 0.
- Count wraps modulo 2^32.
- TI is set when an increment makes Count equal Compare.
- An MTC0 to Compare clears TI; if a set and this clear occur in the same cycle, the clear wins.
- An MTC0 to Count loads the value and resets the divider to 0. No increment occurs that cycle.

**Interrupt sources:**
- IP[7:2] is registered from hw_int each cycle (zero-extended to 6 bits).
- IP[7] is additionally ORed with TI.
- int_req = IE & ~EXL & |(IP[7:0] & IM[7:0]). The pipeline raises ex[0] in response.

## Timing

**Reset** (resetn low, asynchronous):
- All registers and the divider are cleared to 0, so Status, Cause, Count, Compare, EPC and BadVAddr all read 0.
- int_req = 0 and epc_out = 0.

**Write and read latency:**
- A register written by MTC0 at edge N is visible on value_out in cycle N+1.
- value_out and epc_out follow register state combinationally.

**Count rate:** with COUNT_DIV=2, Count advances every second clock, with the first increment two clocks after reset release.

**Interrupt latency:**
- hw_int asserted before edge N sets IP at N, so int_req is high in cycle N+1 if enabled.
- TI is set at the same edge Count reaches Compare.

**Reset mid-operation:** any pending TI, EXL or divider phase is discarded immediately.

## Test plan

1. **Reset, then Count.** Reset, release, COUNT_DIV=2 → Count reads 0,0,1,1,2… Then MTC0 Count=0xFFFFFFFF → Count reads 0x00000000 two clocks later, with no TI while Compare=5.
2. **Timer interrupt.** Compare=3, Status=0x00008001 → TI=1 and int_req=1 the cycle after Count reaches 3. Then MTC0 Compare=100 → TI=0 and int_req=0 next cycle.
3. **Nested exception.** Commit Sys at epc_in=0xBFC00100 with is_bd=1 → EPC=0xBFC00100, Cause=0x80000020, EXL=1. Then commit Ov at 0xBFC00200 → EPC and BD are unchanged, ExcCode=0x0c.
4. **Priority and BadVAddr.** ex=8'b1100_0100 with badvaddr_in=0x1234 → ExcCode=0x0a and BadVAddr is unchanged. Then ex=8'b1000_0000 → ExcCode=0x05 and BadVAddr=0x1234.
5. **Simultaneous events.** ERET plus MTC0 Status=0x2 in the same cycle → EXL=0. Exception plus MTC0 EPC=0xDEAD → EPC=epc_in.
6. **Interrupt masking.** hw_int[2]=1 with IM[4]=0 → IP[4]=1 and int_req=0. Write IM[4]=1 → int_req=1 next cycle. Assert resetn=0 → int_req=0 immediately.
